// File: rtl/session_pkg.sv
// Shared types and constants for the access-session controller.
package session_pkg;

  localparam int unsigned USER_W = 4;
  localparam logic [USER_W-1:0] NO_USER = USER_W'(0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SESSION = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that saturates at zero; the zero flag is registered
// so it reads 1 during the cycle in which the count is 0.
module cycle_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_zero <= 1'b1;
    end else if (i_load) begin
      r_cnt  <= i_value;
      r_zero <= (i_value == '0);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt  <= r_cnt - CNT_W'(1);
      r_zero <= (r_cnt == CNT_W'(1));
    end
  end

  assign o_zero = r_zero;

endmodule

// File: rtl/session_ctrl.sv
// Access-session controller: opens timed sessions on passing verdicts,
// counts consecutive failures and enforces a timed lockout.
module session_ctrl
  import session_pkg::*;
#(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCK_CYCLES    = 50_000_000,
  parameter int unsigned SESSION_CYCLES = 500_000_000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              auth_valid,
  input  logic              auth_pass,
  input  logic [USER_W-1:0] auth_user,
  input  logic              logout,
  output logic              ready,
  output logic              access,
  output logic              locked,
  output logic [USER_W-1:0] active_user,
  output logic [1:0]        fail_count,
  output logic              grant_pulse,
  output logic              deny_pulse
);

  localparam logic [CNT_W-1:0] SESS_LOAD = CNT_W'(SESSION_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [1:0]       FAIL_MAX  = 2'(MAX_FAILS);

  state_e            r_state, w_state_nxt;
  logic [USER_W-1:0] r_user, w_user_nxt;
  logic [1:0]        r_fail, w_fail_nxt, w_fail_inc;
  logic              r_ready, r_access, r_locked, r_grant, r_deny;
  logic              w_grant_nxt, w_deny_nxt;
  logic              w_load, w_timer_en, w_zero;
  logic [CNT_W-1:0]  w_load_val;

  assign w_timer_en = (r_state != IDLE);

  cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_timer_en),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_zero  (w_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_user   <= NO_USER;
      r_fail   <= 2'd0;
      r_ready  <= 1'b1;
      r_access <= 1'b0;
      r_locked <= 1'b0;
      r_grant  <= 1'b0;
      r_deny   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_user   <= w_user_nxt;
      r_fail   <= w_fail_nxt;
      r_ready  <= (w_state_nxt == IDLE);
      r_access <= (w_state_nxt == SESSION);
      r_locked <= (w_state_nxt == LOCKOUT);
      r_grant  <= w_grant_nxt;
      r_deny   <= w_deny_nxt;
    end
  end

  // Verdicts are only evaluated in IDLE; SESSION/LOCKOUT wait on the timer.
  always_comb begin
    w_state_nxt = r_state;
    w_user_nxt  = r_user;
    w_fail_nxt  = r_fail;
    w_fail_inc  = r_fail + 2'd1;
    w_grant_nxt = 1'b0;
    w_deny_nxt  = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      IDLE: begin
        if (auth_valid) begin
          if (auth_pass && (auth_user != NO_USER)) begin
            w_state_nxt = SESSION;
            w_user_nxt  = auth_user;
            w_fail_nxt  = 2'd0;
            w_grant_nxt = 1'b1;
            w_load      = 1'b1;
            w_load_val  = SESS_LOAD;
          end else begin
            w_deny_nxt = 1'b1;
            w_fail_nxt = w_fail_inc;
            if (w_fail_inc == FAIL_MAX) begin
              w_state_nxt = LOCKOUT;
              w_load      = 1'b1;
              w_load_val  = LOCK_LOAD;
            end
          end
        end
      end
      SESSION: begin
        if (logout || w_zero) begin
          w_state_nxt = IDLE;
          w_user_nxt  = NO_USER;
        end
      end
      LOCKOUT: begin
        if (w_zero) begin
          w_state_nxt = IDLE;
          w_fail_nxt  = 2'd0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_user_nxt  = NO_USER;
        w_fail_nxt  = 2'd0;
      end
    endcase
  end

  assign ready       = r_ready;
  assign access      = r_access;
  assign locked      = r_locked;
  assign active_user = r_user;
  assign fail_count  = r_fail;
  assign grant_pulse = r_grant;
  assign deny_pulse  = r_deny;

endmodule

// File: doc/session_ctrl.md
# session_ctrl

Access-session controller directly downstream of the credential authentication stage. It consumes each registered pass/fail verdict and the matched user index. It opens a timed access session on success, counts consecutive failures, and enforces a timed lockout after too many failures. Its outputs drive the access indicator, the lock indicator and the user display path.

## Interface
Parameters:
- MAX_FAILS, 3 — consecutive failures that trigger lockout; legal range 1..3.
- LOCK_CYCLES, 50_000_000 — lockout duration in clk cycles; must be ≥ 1.
- SESSION_CYCLES, 500_000_000 — session timeout in clk cycles; must be ≥ 1.
- CNT_W, 32 — timer width; must hold max(LOCK_CYCLES, SESSION_CYCLES).

Ports:
- clk  in  1  — single system clock; all logic on rising edge.
- rst  in  1  — asynchronous, active-low reset.
- auth_valid  in  1  — one-cycle pulse: a verdict is present.
- auth_pass  in  1  — verdict; sampled only when auth_valid=1.
- auth_user  in  4  — matched user index; sampled only when auth_valid=1. Value 0 is reserved and means "no user".
- logout  in  1  — one-cycle pulse from the shaped logout button.
- ready  out  1  — 1 only in IDLE; verdicts are accepted only while ready=1.
- access  out  1  — 1 while in SESSION.
- locked  out  1  — 1 while in LOCKOUT.
- active_user  out  4  — latched user index in SESSION; 0 otherwise.
- fail_count  out  2  — current consecutive-failure count.
- grant_pulse  out  1  — one-cycle pulse on session open.
- deny_pulse  out  1  — one-cycle pulse on each counted failure.

## Operation
- States: IDLE, SESSION, LOCKOUT.
- Reset values: state=IDLE, timer=0, ready=1, access=0, locked=0, active_user=0, fail_count=0, grant_pulse=0, deny_pulse=0.
- All outputs are registered.

IDLE:
- Success is auth_valid=1, auth_pass=1 and auth_user≠0.
  - Go to SESSION.
  - Latch auth_user.
  - Clear fail_count.
  - Load timer with SESSION_CYCLES-1.
  - Assert grant_pulse.
- Failure is auth_valid=1 with auth_pass=0, or with auth_pass=1 and auth_user=0.
  - Assert deny_pulse.
  - Increment fail_count.
  - If the new count equals MAX_FAILS: go to LOCKOUT and load timer with LOCK_CYCLES-1. fail_count holds MAX_FAILS during the lockout.
- logout in IDLE: ignored.

SESSION:
- Timer decrements by 1 each cycle.
- logout=1 or timer=0 → IDLE, with active_user=0.
- Simultaneous logout and timer=0 → a single exit to IDLE, no other effect.
- auth_valid in SESSION: ignored; no re-login and no failure count.

LOCKOUT:
- Timer decrements by 1 each cycle.
- timer=0 → IDLE with fail_count cleared to 0.
- auth_valid and logout: ignored. No deny_pulse is raised.

General:
- fail_count never exceeds MAX_FAILS and never wraps.
- A successful login resets fail_count; a session ending does not change it, since it is already 0.
- Reset asserted mid-SESSION or mid-LOCKOUT: every output returns to its reset value immediately, without waiting for a clock edge.

## Timing
- Verdict in cycle N → state, access/locked/active_user/fail_count and the matching pulse are all updated at edge N+1.
- ready falls at N+1. A second auth_valid in cycle N+1 is ignored.
- Session length: access is high for exactly SESSION_CYCLES cycles when no logout occurs.
- Logout in cycle M → access=0 at edge M+1.
- Lockout length: locked is high for exactly LOCK_CYCLES cycles. ready=1 and fail_count=0 on the first cycle after that.
- grant_pulse and deny_pulse are each exactly one cycle wide.
- Reset deassertion is synchronised externally. The block accepts a verdict on the first clock after rst goes high.

## Structure
- Shared package session_pkg holds:
  - the state enum (IDLE, SESSION, LOCKOUT), 2 bits;
  - the reserved NO_USER=4'd0 constant;
  - the user-index width constant USER_W=4.
- One sub-module, cycle_timer: a loadable CNT_W down-counter with load/value inputs and a registered zero flag. It is shared by SESSION and LOCKOUT, which are mutually exclusive.
- The FSM and output registers stay in session_ctrl.

## Test plan
All scenarios use MAX_FAILS=3, LOCK_CYCLES=8, SESSION_CYCLES=16.

- Pass, user 5: access=1 and active_user=5 one cycle later; grant_pulse for 1 cycle; access stays high exactly 16 cycles, then ready=1.
- Pass, user 3, then logout at cycle 4 of the session: access=0 and active_user=0 next edge; logout coinciding with timer=0 gives a single clean return to IDLE.
- Three fails: fail_count goes 1, 2, 3 with three deny_pulses; locked=1 for exactly 8 cycles; auth_valid with pass during lockout is ignored; fail_count=0 afterwards.
- Two fails then a pass with user 2: fail_count=0 and access=1. Then a pass with auth_user=0: counted as a fail, deny_pulse raised, fail_count=1, no session.
- auth_valid on consecutive cycles (pass then fail): only the first is taken; SESSION entered; fail_count stays 0.
- rst asserted mid-session and again mid-lockout: all outputs at reset values immediately; after release, a pass with user 7 opens a session normally.
